// File: rtl/pipeline_latealu.sv
// Late ALU stage: single-cycle srl/sra, iterative mult/div into HI/LO,
// HI/LO moves, and ALU-stage passthrough. Stalls dependent ops while busy.
module pipeline_latealu #(
  parameter int unsigned ITER_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        latealu_enable,
  input  logic [5:0]  latealu_op,
  input  logic [31:0] latealu_a0,
  input  logic [31:0] latealu_a1,
  input  logic [4:0]  rd_index_in,
  input  logic [31:0] rd_value_in,
  output logic [4:0]  rd_index,
  output logic [31:0] rd_value,
  output logic        stall,
  output logic        busy,
  output logic [2:0]  exception
);

  localparam logic [5:0] OpSrl   = 6'b000010;
  localparam logic [5:0] OpSra   = 6'b000011;
  localparam logic [5:0] OpMult  = 6'b011000;
  localparam logic [5:0] OpMultu = 6'b011001;
  localparam logic [5:0] OpDiv   = 6'b011010;
  localparam logic [5:0] OpDivu  = 6'b011011;
  localparam logic [5:0] OpMfhi  = 6'b010000;
  localparam logic [5:0] OpMthi  = 6'b010001;
  localparam logic [5:0] OpMflo  = 6'b010010;
  localparam logic [5:0] OpMtlo  = 6'b010011;

  localparam int unsigned CntW = $clog2(ITER_CYCLES + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       work_q, work_d;    // {partial product} or {remainder, quotient}
  logic [31:0]       opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [31:0]       a0_q, a0_d;        // original dividend for divide-by-zero HI
  logic              is_div_q, is_div_d;
  logic              neg_lo_q, neg_lo_d;
  logic              neg_hi_q, neg_hi_d;
  logic              dz_q, dz_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [4:0]        rd_index_q, rd_index_d;
  logic [31:0]       rd_value_q, rd_value_d;
  logic [2:0]        exc_q, exc_d;

  logic        is_muldiv, is_hilo, signed_op, sa0, sa1;
  logic [31:0] mag0, mag1;
  logic [32:0] mul_sum, div_shift, div_sub;
  logic [63:0] step_next, prod;
  logic [31:0] quo, rem;

  assign busy      = (state_q == StRun);
  assign is_muldiv = (latealu_op[5:2] == 4'b0110);
  assign is_hilo   = (latealu_op[5:2] == 4'b0100);
  assign stall     = latealu_enable & busy & (is_muldiv | is_hilo);

  assign signed_op = ~latealu_op[0];
  assign sa0       = signed_op & latealu_a0[31];
  assign sa1       = signed_op & latealu_a1[31];
  assign mag0      = sa0 ? 32'd0 - latealu_a0 : latealu_a0;
  assign mag1      = sa1 ? 32'd0 - latealu_a1 : latealu_a1;

  // One iteration step: shift-add for mult, restoring subtract for div.
  always_comb begin
    mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_shift = {work_q[63:32], work_q[31]};
    div_sub   = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      // No borrow means the shifted remainder covers the divisor.
      step_next = {(div_sub[32] ? div_shift[31:0] : div_sub[31:0]), work_q[30:0], ~div_sub[32]};
    end else begin
      step_next = {mul_sum, work_q[31:1]};
    end
    prod = neg_lo_q ? 64'd0 - step_next : step_next;
    quo  = neg_lo_q ? 32'd0 - step_next[31:0] : step_next[31:0];
    rem  = neg_hi_q ? 32'd0 - step_next[63:32] : step_next[63:32];
  end

  // Next-state: op decode, operand capture, iteration and HI/LO update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    opnd_d     = opnd_q;
    a0_d       = a0_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_index_d = 5'd0;
    rd_value_d = rd_value_q;
    exc_d      = 3'b000;

    if (!latealu_enable) begin
      rd_index_d = rd_index_in;
      rd_value_d = rd_value_in;
    end else if (!stall) begin
      case (latealu_op)
        OpSrl: begin
          rd_index_d = rd_index_in;
          rd_value_d = latealu_a0 >> latealu_a1[4:0];
        end
        OpSra: begin
          rd_index_d = rd_index_in;
          rd_value_d = $unsigned($signed(latealu_a0) >>> latealu_a1[4:0]);
        end
        OpMfhi: begin
          rd_index_d = rd_index_in;
          rd_value_d = hi_q;
        end
        OpMflo: begin
          rd_index_d = rd_index_in;
          rd_value_d = lo_q;
        end
        OpMthi: hi_d = latealu_a0;
        OpMtlo: lo_d = latealu_a0;
        OpMult, OpMultu, OpDiv, OpDivu: begin
          state_d  = StRun;
          cnt_d    = CntW'(ITER_CYCLES);
          is_div_d = latealu_op[1];
          neg_lo_d = sa0 ^ sa1;
          neg_hi_d = sa0;
          dz_d     = latealu_op[1] & (latealu_a1 == 32'd0);
          a0_d     = latealu_a0;
          work_d   = {32'd0, (latealu_op[1] ? mag0 : mag1)};
          opnd_d   = latealu_op[1] ? mag1 : mag0;
        end
        default: exc_d = 3'b001;
      endcase
    end

    // HI/LO moves stall while busy, so completion never collides with them.
    if (state_q == StRun) begin
      work_d = step_next;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        state_d = StIdle;
        if (!is_div_q) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (dz_q) begin
          hi_d = a0_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      a0_q       <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_index_q <= '0;
      rd_value_q <= '0;
      exc_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      opnd_q     <= opnd_d;
      a0_q       <= a0_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_index_q <= rd_index_d;
      rd_value_q <= rd_value_d;
      exc_q      <= exc_d;
    end
  end

  assign rd_index  = rd_index_q;
  assign rd_value  = rd_value_q;
  assign exception = exc_q;

endmodule

// File: tb/tb_pipeline_latealu.sv
// Directed self-checking bench for pipeline_latealu.
module tb_pipeline_latealu;

  localparam logic [5:0] OpSrl   = 6'b000010;
  localparam logic [5:0] OpSra   = 6'b000011;
  localparam logic [5:0] OpMult  = 6'b011000;
  localparam logic [5:0] OpMultu = 6'b011001;
  localparam logic [5:0] OpDiv   = 6'b011010;
  localparam logic [5:0] OpDivu  = 6'b011011;
  localparam logic [5:0] OpMfhi  = 6'b010000;
  localparam logic [5:0] OpMthi  = 6'b010001;
  localparam logic [5:0] OpMflo  = 6'b010010;
  localparam logic [5:0] OpMtlo  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [5:0]  op;
  logic [31:0] a0, a1;
  logic [4:0]  idx_in;
  logic [31:0] val_in;
  logic [4:0]  rd_index;
  logic [31:0] rd_value;
  logic        stall, busy;
  logic [2:0]  exception;

  int checks = 0;
  int failures = 0;

  pipeline_latealu #(.ITER_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .latealu_enable(en), .latealu_op(op), .latealu_a0(a0), .latealu_a1(a1),
    .rd_index_in(idx_in), .rd_value_in(val_in),
    .rd_index(rd_index), .rd_value(rd_value),
    .stall(stall), .busy(busy), .exception(exception)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [5:0] o, input logic [31:0] x0,
                       input logic [31:0] x1, input logic [4:0] i, input logic [31:0] v);
    en = e; op = o; a0 = x0; a1 = x1; idx_in = i; val_in = v;
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic read_hl(input logic sel_hi, output logic [31:0] v);
    drive(1'b1, sel_hi ? OpMfhi : OpMflo, 32'd0, 32'd0, 5'd1, 32'd0);
    step();
    v = rd_value;
    drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    checks++; if (rd_index !== 5'd0) begin failures++; $display("FAIL reset_idx got %h want 00", rd_index); end
    checks++; if (rd_value !== 32'd0) begin failures++; $display("FAIL reset_val got %h want 0", rd_value); end
    checks++; if (exception !== 3'd0) begin failures++; $display("FAIL reset_exc got %b want 000", exception); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_shift();
    drive(1'b1, OpSra, 32'h8000_0000, 32'd4, 5'd9, 32'd0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sra_stall got %b want 0", stall); end
    step();
    checks++; if (rd_index !== 5'd9) begin failures++; $display("FAIL sra_idx got %0d want 9", rd_index); end
    checks++; if (rd_value !== 32'hF800_0000) begin failures++; $display("FAIL sra_val got %h want f8000000", rd_value); end
    drive(1'b1, OpSrl, 32'h8000_0000, 32'd4, 5'd9, 32'd0);
    step();
    checks++; if (rd_value !== 32'h0800_0000) begin failures++; $display("FAIL srl_val got %h want 08000000", rd_value); end
    // Only a1[4:0] is the shift amount: 0x24 means shift by 4.
    drive(1'b1, OpSra, 32'h7000_0010, 32'h24, 5'd2, 32'd0);
    step();
    checks++; if (rd_value !== 32'h0700_0001) begin failures++; $display("FAIL sra_pos got %h want 07000001", rd_value); end
    drive(1'b1, OpSrl, 32'hFFFF_FFFF, 32'd31, 5'd2, 32'd0);
    step();
    checks++; if (rd_value !== 32'h0000_0001) begin failures++; $display("FAIL srl_31 got %h want 00000001", rd_value); end
  endtask

  task automatic test_bad_op();
    drive(1'b1, 6'b111111, 32'd1, 32'd1, 5'd12, 32'd0);
    step();
    checks++; if (exception !== 3'b001) begin failures++; $display("FAIL badop_exc got %b want 001", exception); end
    checks++; if (rd_index !== 5'd0) begin failures++; $display("FAIL badop_idx got %0d want 0", rd_index); end
    drive(1'b0, 6'b111111, 32'd0, 32'd0, 5'd4, 32'h1234);
    step();
    checks++; if (rd_index !== 5'd4) begin failures++; $display("FAIL pass_idx got %0d want 4", rd_index); end
    checks++; if (rd_value !== 32'h1234) begin failures++; $display("FAIL pass_val got %h want 1234", rd_value); end
    checks++; if (exception !== 3'b000) begin failures++; $display("FAIL pass_exc got %b want 000", exception); end
  endtask

  task automatic test_hilo_move();
    logic [31:0] v;
    drive(1'b1, OpMthi, 32'hAAAA_0000, 32'd0, 5'd3, 32'd0);
    step();
    checks++; if (rd_index !== 5'd0) begin failures++; $display("FAIL mthi_idx got %0d want 0", rd_index); end
    drive(1'b1, OpMtlo, 32'h0000_5555, 32'd0, 5'd3, 32'd0);
    step();
    read_hl(1'b1, v);
    checks++; if (v !== 32'hAAAA_0000) begin failures++; $display("FAIL mthi_rd got %h want aaaa0000", v); end
    read_hl(1'b0, v);
    checks++; if (v !== 32'h0000_5555) begin failures++; $display("FAIL mtlo_rd got %h want 00005555", v); end
  endtask

  task automatic test_mult_signed();
    int n;
    int bad;
    logic [31:0] v;
    drive(1'b1, OpMult, 32'hFFFF_FFFD, 32'd5, 5'd3, 32'd0);
    step();
    checks++; if (rd_index !== 5'd0) begin failures++; $display("FAIL mult_idx got %0d want 0", rd_index); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mult_busy got %b want 1", busy); end
    drive(1'b1, OpMfhi, 32'd0, 32'd0, 5'd7, 32'd0);
    n = 0; bad = 0;
    while (stall === 1'b1 && n < 100) begin
      step();
      if (rd_index !== 5'd0) bad++;
      n++;
    end
    checks++; if (n != 32) begin failures++; $display("FAIL mult_stall_len got %0d want 32", n); end
    checks++; if (bad != 0) begin failures++; $display("FAIL mult_bubble got %0d nonzero want 0", bad); end
    step();
    checks++; if (rd_index !== 5'd7) begin failures++; $display("FAIL mfhi_idx got %0d want 7", rd_index); end
    checks++; if (rd_value !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got %h want ffffffff", rd_value); end
    read_hl(1'b0, v);
    checks++; if (v !== 32'hFFFF_FFF1) begin failures++; $display("FAIL mult_lo got %h want fffffff1", v); end
  endtask

  task automatic test_div();
    int n;
    logic [31:0] v;
    // {op, a0, a1, lo, hi}
    logic [5:0]  t_op [4] = '{OpDiv, OpDivu, OpDiv, OpDiv};
    logic [31:0] t_a0 [4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB};
    logic [31:0] t_a1 [4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_lo [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] t_hi [4] = '{32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFFB};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, t_op[i], t_a0[i], t_a1[i], 5'd8, 32'd0);
      step();
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 32'd0);
      wait_idle(n);
      checks++; if (n != 32) begin failures++; $display("FAIL div%0d_len got %0d want 32", i, n); end
      checks++; if (exception !== 3'b000) begin failures++; $display("FAIL div%0d_exc got %b want 000", i, exception); end
      read_hl(1'b0, v);
      checks++; if (v !== t_lo[i]) begin failures++; $display("FAIL div%0d_lo got %h want %h", i, v, t_lo[i]); end
      read_hl(1'b1, v);
      checks++; if (v !== t_hi[i]) begin failures++; $display("FAIL div%0d_hi got %h want %h", i, v, t_hi[i]); end
    end
  endtask

  task automatic test_multu_overlap();
    int n;
    logic [31:0] v;
    drive(1'b1, OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'd0);
    step();
    drive(1'b1, OpSrl, 32'h0000_00F0, 32'd4, 5'd5, 32'd0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ovl_srl_stall got %b want 0", stall); end
    step();
    checks++; if (rd_index !== 5'd5) begin failures++; $display("FAIL ovl_srl_idx got %0d want 5", rd_index); end
    checks++; if (rd_value !== 32'h0000_000F) begin failures++; $display("FAIL ovl_srl_val got %h want 0000000f", rd_value); end
    drive(1'b1, OpMthi, 32'hDEAD_BEEF, 32'd0, 5'd0, 32'd0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ovl_mthi_stall got %b want 1", stall); end
    step();
    drive(1'b1, OpMtlo, 32'hDEAD_BEEF, 32'd0, 5'd0, 32'd0);
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL ovl_mtlo_stall got %b want 1", stall); end
    step();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 32'd0);
    wait_idle(n);
    checks++; if (n != 29) begin failures++; $display("FAIL ovl_len got %0d want 29", n); end
    read_hl(1'b1, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got %h want fffffffe", v); end
    read_hl(1'b0, v);
    checks++; if (v !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got %h want 00000001", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    drive(1'b1, OpDiv, 32'd100, 32'd3, 5'd0, 32'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 6'd0, 32'd0, 32'd0, 5'd6, 32'h66);
      step();
    end
    checks++; if (rd_index !== 5'd6) begin failures++; $display("FAIL rmid_pre_idx got %0d want 6", rd_index); end
    #1 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (rd_index !== 5'd0) begin failures++; $display("FAIL rmid_idx got %0d want 0", rd_index); end
    step();
    rst = 1'b1;
    drive(1'b1, OpMflo, 32'd0, 32'd0, 5'd11, 32'd0);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rmid_stall got %b want 0", stall); end
    step();
    checks++; if (rd_index !== 5'd11) begin failures++; $display("FAIL rmid_mflo_idx got %0d want 11", rd_index); end
    checks++; if (rd_value !== 32'd0) begin failures++; $display("FAIL rmid_lo got %h want 0", rd_value); end
    read_hl(1'b1, v);
    checks++; if (v !== 32'd0) begin failures++; $display("FAIL rmid_hi got %h want 0", v); end
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0; op = 6'd0; a0 = 32'd0; a1 = 32'd0; idx_in = 5'd0; val_in = 32'd0;
    #2;
    test_reset();
    #10 rst = 1'b1;
    step();
    test_shift();
    test_bad_op();
    test_hilo_move();
    test_mult_signed();
    test_div();
    test_multu_overlap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait ever fails to bound itself.
  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
